// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH-stage valid/ready pipeline register with optional skid buffers, flush and occupancy count
module elastic_pipe_reg #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int SKID  = 1,
    localparam int CW   = $clog2(2 * DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CW-1:0]    count
);
    // vin/din[k] is what stage k sees from upstream; index DEPTH is the block output
    logic [DEPTH:0]   vin, rdy;
    logic [WIDTH-1:0] din [DEPTH+1];
    logic [CW-1:0]    cnt_q, cnt_d;

    assign in_ready  = rdy[0];
    assign out_valid = vin[DEPTH];
    assign out_data  = din[DEPTH];
    assign count     = cnt_q;
    assign cnt_d     = flush ? '0 : cnt_q + CW'(in_valid && in_ready) - CW'(out_valid && out_ready);

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;

    if (SKID != 0) begin : g_skid
        logic [DEPTH-1:0] mv_q, mv_d, sv_q, sv_d;
        logic [WIDTH-1:0] m_q [DEPTH], m_d [DEPTH], s_q [DEPTH], s_d [DEPTH];
        always_comb begin
            vin    = {mv_q, in_valid};
            rdy    = {out_ready, ~sv_q};
            din[0] = in_data;
            for (int k = 0; k < DEPTH; k++) din[k+1] = m_q[k];
            mv_d = mv_q;
            sv_d = sv_q;
            m_d  = m_q;
            s_d  = s_q;
            for (int k = 0; k < DEPTH; k++) begin
                if (sv_q[k]) begin
                    if (rdy[k+1]) begin
                        m_d[k]  = s_q[k];
                        sv_d[k] = 1'b0;
                    end
                end else if (vin[k]) begin
                    mv_d[k] = 1'b1;
                    if (!mv_q[k] || rdy[k+1]) m_d[k] = din[k];
                    else begin
                        s_d[k]  = din[k];
                        sv_d[k] = 1'b1;
                    end
                end else if (rdy[k+1]) begin
                    mv_d[k] = 1'b0;
                end
            end
            if (flush) begin
                mv_d = '0;
                sv_d = '0;
            end
        end
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                mv_q <= '0;
                sv_q <= '0;
                m_q  <= '{default: '0};
                s_q  <= '{default: '0};
            end else begin
                mv_q <= mv_d;
                sv_q <= sv_d;
                m_q  <= m_d;
                s_q  <= s_d;
            end
    end else begin : g_flat
        logic [DEPTH-1:0] v_q, v_d;
        logic [WIDTH-1:0] d_q [DEPTH], d_d [DEPTH];
        always_comb begin
            vin    = {v_q, in_valid};
            din[0] = in_data;
            for (int k = 0; k < DEPTH; k++) din[k+1] = d_q[k];
            rdy        = '0;
            rdy[DEPTH] = out_ready;
            for (int k = DEPTH - 1; k >= 0; k--) rdy[k] = !v_q[k] || rdy[k+1];
            v_d = v_q;
            d_d = d_q;
            for (int k = 0; k < DEPTH; k++) begin
                v_d[k] = rdy[k] ? vin[k] : v_q[k];
                d_d[k] = (rdy[k] && vin[k]) ? din[k] : d_q[k];
            end
            if (flush) v_d = '0;
        end
        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                v_q <= '0;
                d_q <= '{default: '0};
            end else begin
                v_q <= v_d;
                d_q <= d_d;
            end
    end
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: directed + random scoreboard bench over several WIDTH/DEPTH/SKID instances
module tb_elastic_pipe_reg;
    localparam int N = 7;
    localparam int WS [N] = '{32, 32, 1, 77, 77, 32, 1};
    localparam int DS [N] = '{2, 2, 1, 3, 8, 1, 8};
    localparam int SS [N] = '{1, 0, 1, 0, 1, 0, 0};

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, flush;
    logic [76:0] in_data;
    logic        ir [N], ov [N];
    logic [76:0] od [N];
    logic [4:0]  cnt [N];
    int          n_vec = 0, n_err = 0;
    int          acc0, acc1;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W  = WS[g];
        localparam int D  = DS[g];
        localparam int CW = $clog2(2 * D + 1);
        logic [W-1:0]  o, held;
        logic [CW-1:0] c;
        logic [W-1:0]  q [$];
        logic          stall = 1'b0;

        elastic_pipe_reg #(.WIDTH(W), .DEPTH(D), .SKID(SS[g])) u_dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[g]), .in_data(in_data[W-1:0]),
            .out_valid(ov[g]), .out_ready(out_ready), .out_data(o), .flush(flush), .count(c)
        );
        assign od[g]  = 77'(o);
        assign cnt[g] = 5'(c);

        // inputs only change just after posedge, so at negedge we see exactly what the next edge will do
        always @(negedge clk) begin
            if (!rst) begin
                q.delete();
                stall = 1'b0;
            end else begin
                n_vec++;
                assert (int'(c) === q.size())
                else begin n_err++; $error("FAIL count%0d got %0d want %0d", g, c, q.size()); end
                if (stall) begin
                    n_vec++;
                    assert (ov[g] === 1'b1 && o === held)
                    else begin n_err++; $error("FAIL stable%0d got v=%b %h want v=1 %h", g, ov[g], o, held); end
                end
                if (ov[g] && out_ready) begin
                    n_vec++;
                    assert (q.size() > 0 && o === q[0])
                    else begin n_err++; $error("FAIL data%0d got %h want %h (queued %0d)", g, o, q.size() > 0 ? q[0] : '0, q.size()); end
                    if (q.size() > 0) void'(q.pop_front());
                end
                if (flush) q.delete();
                else if (in_valid && ir[g]) q.push_back(in_data[W-1:0]);
                stall = ov[g] && !out_ready && !flush;
                held  = o;
            end
        end
    end

    task automatic chk(input string tag, input logic [76:0] obs, input logic [76:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin n_err++; $error("FAIL %s got %h want %h", tag, obs, exp); end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [76:0] msk(input int v, input int w);
        logic [76:0] m;
        m = (77'(1) << w) - 77'(1);
        return 77'(v) & m;
    endfunction

    task automatic chk_idle(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_ov%0d", tag, i), 77'(ov[i]), 77'(0));
            chk($sformatf("%s_cnt%0d", tag, i), 77'(cnt[i]), 77'(0));
            chk($sformatf("%s_ir%0d", tag, i), 77'(ir[i]), 77'(1));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
        #1 rst = 1'b0;
        #1;
        chk_idle("reset");
        for (int i = 0; i < N; i++) chk($sformatf("reset_od%0d", i), od[i], 77'(0));
        repeat (2) step();
        rst = 1'b1;
        chk_idle("release");

        // streaming: latency DEPTH-1 edges after accept, then one word per cycle
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_data = 77'(k + 1);
            step();
            for (int i = 0; i < N; i++) begin
                chk($sformatf("stream_ov%0d_%0d", i, k), 77'(ov[i]), 77'(k >= DS[i] - 1));
                if (k >= DS[i] - 1) chk($sformatf("stream_od%0d_%0d", i, k), od[i], msk(k - DS[i] + 2, WS[i]));
                chk($sformatf("stream_cnt%0d_%0d", i, k), 77'(cnt[i]), 77'(k + 1 < DS[i] ? k + 1 : DS[i]));
                chk($sformatf("stream_ir%0d_%0d", i, k), 77'(ir[i]), 77'(1));
            end
        end
        in_valid = 1'b0;
        repeat (9) step();
        chk_idle("stream_end");

        // fill under stall
        out_ready = 1'b0; in_valid = 1'b1; acc0 = 0; acc1 = 0;
        for (int j = 0; j < 6; j++) begin
            in_data = 77'('hA0 + j);
            #1;
            acc0 += int'(ir[0]);
            acc1 += int'(ir[1]);
            step();
        end
        chk("fill_acc_skid", 77'(acc0), 77'(4));
        chk("fill_acc_flat", 77'(acc1), 77'(2));
        chk("fill_cnt_skid", 77'(cnt[0]), 77'(4));
        chk("fill_cnt_flat", 77'(cnt[1]), 77'(2));
        chk("fill_ir_skid", 77'(ir[0]), 77'(0));
        chk("fill_ir_flat", 77'(ir[1]), 77'(0));
        chk("fill_od_skid", od[0], 77'('hA0));
        chk("fill_od_flat", od[1], 77'('hA0));

        // out_ready must not reach in_ready combinationally with skid buffers
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("nocomb_ir_skid", 77'(ir[0]), 77'(0));
        chk("comb_ir_flat", 77'(ir[1]), 77'(1));
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain_ov_%0d", j), 77'(ov[0]), 77'(1));
            chk($sformatf("drain_od_%0d", j), od[0], 77'('hA0 + j));
            chk($sformatf("drain_ir_%0d", j), 77'(ir[0]), 77'(j >= 2));
            step();
        end
        chk("drain_cnt", 77'(cnt[0]), 77'(0));
        chk("drain_ov", 77'(ov[0]), 77'(0));
        repeat (16) step();
        chk_idle("drain_end");

        // flush with a simultaneous input transfer
        out_ready = 1'b0; in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_data = 77'('hC0 + j);
            step();
        end
        chk("preflush_cnt", 77'(cnt[0]), 77'(3));
        in_data = 77'('hAA); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk_idle("flush");
        in_valid = 1'b1; in_data = 77'('hBB); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bb_ov_first", 77'(ov[0]), 77'(0));
        chk("bb_d1_ov", 77'(ov[2]), 77'(1));
        chk("bb_d1_od", od[2], msk('hBB, 1));
        step();
        chk("bb_ov", 77'(ov[0]), 77'(1));
        chk("bb_od", od[0], 77'('hBB));
        repeat (10) step();

        // asynchronous reset while holding entries
        out_ready = 1'b0; in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_data = 77'('hD0 + j);
            step();
        end
        chk("prereset_cnt", 77'(cnt[0]), 77'(3));
        in_valid = 1'b0; rst = 1'b0;
        #1;
        chk_idle("midreset");
        for (int i = 0; i < N; i++) chk($sformatf("midreset_od%0d", i), od[i], 77'(0));
        step();
        rst = 1'b1; out_ready = 1'b1;
        repeat (12) step();
        chk_idle("postreset");

        // random traffic with occasional flush
        for (int t = 0; t < 10000; t++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 49) == 0);
            in_data   = 77'({$urandom(), $urandom(), $urandom()});
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) step();
        chk_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
